dfdd_pixel_source: RTL and testbench
====================================

Name: dfdd_pixel_source

Overview:
Front-end feeder for the DFDD core. It takes the raw uint8 rho-plus/rho-minus pixel stream and converts each sample to the core's floating-point format (sign, exponent, fraction). It tags each pixel with raster col/row coordinates and drives the core's input side. It has a fixed-latency pipeline and no backpressure, matching the core's valid-only protocol.

Parameters:
EXP_WIDTH, 5, exponent field width; must be >= 4
FRAC_WIDTH, 10, fraction field width; must be >= 1
IMG_WIDTH, 640, pixels per row; 1..65535
IMG_HEIGHT, 480, rows per frame; 1..65535
FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local parameter; not overridable

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
rho_plus_uint8_i  in  8  raw rho-plus sample
rho_minus_uint8_i  in  8  raw rho-minus sample
sof_i  in  1  start-of-frame marker; qualified by valid_i
valid_i  in  1  input sample valid
i_rho_plus_o  out  FP_WIDTH_REG  converted rho-plus, drives core i_rho_plus_i
i_rho_minus_o  out  FP_WIDTH_REG  converted rho-minus, drives core i_rho_minus_i
col_o  out  16  column of output pixel
row_o  out  16  row of output pixel
valid_o  out  1  output valid, drives core valid_i
frame_done_o  out  1  one-cycle pulse with valid_o of last pixel (col=IMG_WIDTH-1, row=IMG_HEIGHT-1)
sof_err_o  out  1  sticky: sof_i seen while position counter not at (0,0)

Behaviour:
- Reset (rst_i=1 at a clock edge): all outputs are 0. Col/row counters are 0. Pipeline valid bits are cleared. sof_err_o is cleared. Reset mid-frame discards in-flight pixels; no valid_o is issued for them.
- Latency: exactly 2 cycles from valid_i to valid_o. The output fields of one pixel are mutually aligned.
  - Stage 1 registers the samples, computes leading-one position and captures col/row.
  - Stage 2 packs the FP words.
- With valid_i=0, valid_o follows 2 cycles later as 0. Data outputs hold their last value.
- Coordinate assignment on valid_i=1:
  - If sof_i=1, the pixel is (0,0).
  - Otherwise the pixel gets the current (col_cnt,row_cnt).
  - After assignment, the counter advances from the assigned position: col+1. At col=IMG_WIDTH-1, col wraps to 0 and row+1. At row=IMG_HEIGHT-1 with col=IMG_WIDTH-1, both wrap to 0.
- sof_i with valid_i=0 is ignored.
- sof_err_o: set when valid_i=1, sof_i=1 and (col_cnt,row_cnt) != (0,0), i.e. a short frame. It stays set until reset. Coordinates still resync to (0,0).
- frame_done_o=1 exactly when valid_o=1 and the output pixel is (IMG_WIDTH-1, IMG_HEIGHT-1).
- IMG_WIDTH=1 or IMG_HEIGHT=1 must work, including the degenerate 1x1 case where every pixel pulses frame_done_o.
- uint8 to FP conversion, identical for both channels:
  - bias = 2^(EXP_WIDTH-1)-1; sign = 0 always.
  - v=0: output all zeros.
  - v>0: p = leading-one index (0..7); exponent = p+bias.
  - fraction = bits v[p-1:0] left-aligned into FRAC_WIDTH, zero-filled. If FRAC_WIDTH < p, truncate the LSBs (round toward zero).
  - No denormals and no overflow; guaranteed by EXP_WIDTH >= 4.
- Back-to-back valid_i at full rate is sustained indefinitely. There is no stall path.

Test Plan:
- E5/F10, IMG 4x2; samples 0,1,3,128,255 on consecutive cycles -> i_rho_plus_o = 0x0000, 0x3C00, 0x4200, 0x5800, 0x5BF8, each exactly 2 cycles after its input.
- IMG 4x2; 8 back-to-back valids with sof_i on the first -> (col,row) sequence (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(3,1). frame_done_o pulses only on (3,1). Pixel 9 comes out at (0,0).
- IMG 4x2; valid_i gapped 1-on/2-off -> same coordinate sequence; valid_o gaps mirror the input; data outputs hold during gaps.
- IMG 4x2; sof_i at pixel 3 of a frame -> that pixel is (0,0), sof_err_o=1 from the next cycle; rst_i clears it to 0.
- Assert rst_i for 1 cycle while 2 pixels are in flight -> no valid_o for them; the next valid_i (no sof_i) outputs at (0,0).
- E8/F3, rho_minus=255 -> exponent 134, fraction 0b111 (truncated): i_rho_minus_o = 0x437; rho_minus=1 -> 0x3F8.

Source files
------------

// File: rtl/dfdd_pixel_source_if.sv
// rtl/dfdd_pixel_source_if.sv - uint8 pixel input stream and FP pixel output stream of the DFDD feeder
// master drives samples and observes results; slave is the feeder itself.
interface dfdd_pixel_source_if #(
   parameter int EXP_WIDTH  = 5,
   parameter int FRAC_WIDTH = 10
);
   localparam int FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

   logic [7:0]          rho_plus_uint8_i;
   logic [7:0]          rho_minus_uint8_i;
   logic                sof_i;
   logic                valid_i;
   logic [FP_WIDTH-1:0] i_rho_plus_o;
   logic [FP_WIDTH-1:0] i_rho_minus_o;
   logic [15:0]         col_o;
   logic [15:0]         row_o;
   logic                valid_o;
   logic                frame_done_o;
   logic                sof_err_o;

   modport master (
      output rho_plus_uint8_i, rho_minus_uint8_i, sof_i, valid_i,
      input  i_rho_plus_o, i_rho_minus_o, col_o, row_o, valid_o, frame_done_o, sof_err_o
   );

   modport slave (
      input  rho_plus_uint8_i, rho_minus_uint8_i, sof_i, valid_i,
      output i_rho_plus_o, i_rho_minus_o, col_o, row_o, valid_o, frame_done_o, sof_err_o
   );
endinterface

// File: rtl/dfdd_pixel_source.sv
// rtl/dfdd_pixel_source.sv - uint8 to FP converter and raster tagger feeding the DFDD core
// Two-stage valid-only pipeline; the interface instance must use the same EXP/FRAC widths.
module dfdd_pixel_source #(
   parameter int EXP_WIDTH  = 5,
   parameter int FRAC_WIDTH = 10,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   dfdd_pixel_source_if.slave   pix
);
   localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
   localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
   localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);
   localparam logic [EXP_WIDTH-1:0] BIAS = EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 1);

   function automatic logic [2:0] lead_one(input logic [7:0] v);
      logic [2:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) p = 3'(i);
      end
      return p;
   endfunction

   // Bits below the leading one, MSB-first into the fraction; excess LSBs drop (round toward zero).
   function automatic logic [FRAC_WIDTH-1:0] frac_align(input logic [7:0] v, input logic [2:0] p);
      logic [FRAC_WIDTH-1:0] f;
      int src;
      f = '0;
      for (int i = 0; i < FRAC_WIDTH; i++) begin
         src = int'(p) - 1 - i;
         if (src >= 0) f[FRAC_WIDTH-1-i] = v[3'(src)];
      end
      return f;
   endfunction

   function automatic logic [FP_WIDTH_REG-1:0] pack_fp(input logic [7:0] v, input logic [2:0] p);
      if (v == 8'd0) return '0;
      return {1'b0, EXP_WIDTH'(p) + BIAS, frac_align(v, p)};
   endfunction

   logic [15:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
   logic [15:0] col_asg, row_asg;
   logic        sof_err_q, sof_err_d;

   logic        s1_valid_q;
   logic [7:0]  s1_plus_q, s1_minus_q;
   logic [2:0]  s1_p_plus_q, s1_p_minus_q;
   logic [15:0] s1_col_q, s1_row_q;

   logic                    s2_valid_q, s2_fd_q;
   logic [FP_WIDTH_REG-1:0] s2_plus_q, s2_minus_q, s2_plus_d, s2_minus_d;
   logic [15:0]             s2_col_q, s2_row_q;

   always_comb begin
      col_asg   = pix.sof_i ? 16'd0 : col_cnt_q;
      row_asg   = pix.sof_i ? 16'd0 : row_cnt_q;
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      sof_err_d = sof_err_q;
      if (pix.valid_i) begin
         if (col_asg == COL_LAST) begin
            col_cnt_d = 16'd0;
            row_cnt_d = (row_asg == ROW_LAST) ? 16'd0 : row_asg + 16'd1;
         end else begin
            col_cnt_d = col_asg + 16'd1;
            row_cnt_d = row_asg;
         end
         // A sof arriving anywhere but (0,0) means the previous frame came up short.
         if (pix.sof_i && ((col_cnt_q != 16'd0) || (row_cnt_q != 16'd0))) sof_err_d = 1'b1;
      end
   end

   always_comb begin
      s2_plus_d  = pack_fp(s1_plus_q, s1_p_plus_q);
      s2_minus_d = pack_fp(s1_minus_q, s1_p_minus_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col_cnt_q    <= '0;
         row_cnt_q    <= '0;
         sof_err_q    <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_plus_q    <= '0;
         s1_minus_q   <= '0;
         s1_p_plus_q  <= '0;
         s1_p_minus_q <= '0;
         s1_col_q     <= '0;
         s1_row_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_fd_q      <= 1'b0;
         s2_plus_q    <= '0;
         s2_minus_q   <= '0;
         s2_col_q     <= '0;
         s2_row_q     <= '0;
      end else begin
         col_cnt_q  <= col_cnt_d;
         row_cnt_q  <= row_cnt_d;
         sof_err_q  <= sof_err_d;
         s1_valid_q <= pix.valid_i;
         if (pix.valid_i) begin
            s1_plus_q    <= pix.rho_plus_uint8_i;
            s1_minus_q   <= pix.rho_minus_uint8_i;
            s1_p_plus_q  <= lead_one(pix.rho_plus_uint8_i);
            s1_p_minus_q <= lead_one(pix.rho_minus_uint8_i);
            s1_col_q     <= col_asg;
            s1_row_q     <= row_asg;
         end
         s2_valid_q <= s1_valid_q;
         s2_fd_q    <= s1_valid_q && (s1_col_q == COL_LAST) && (s1_row_q == ROW_LAST);
         // Data outputs hold through idle cycles.
         if (s1_valid_q) begin
            s2_plus_q  <= s2_plus_d;
            s2_minus_q <= s2_minus_d;
            s2_col_q   <= s1_col_q;
            s2_row_q   <= s1_row_q;
         end
      end
   end

   assign pix.i_rho_plus_o  = s2_plus_q;
   assign pix.i_rho_minus_o = s2_minus_q;
   assign pix.col_o         = s2_col_q;
   assign pix.row_o         = s2_row_q;
   assign pix.valid_o       = s2_valid_q;
   assign pix.frame_done_o  = s2_fd_q;
   assign pix.sof_err_o     = sof_err_q;
endmodule

// File: tb/tb_dfdd_pixel_source.sv
// tb/tb_dfdd_pixel_source.sv - scoreboard bench: E5/F10 4x2 feeder and E8/F3 1x1 feeder
// Expected pixels are queued when driven and matched when valid_o appears.
module tb_dfdd_pixel_source;
   localparam int AW = 4;
   localparam int AH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dfdd_pixel_source_if #(.EXP_WIDTH(5), .FRAC_WIDTH(10)) bus_a ();
   dfdd_pixel_source_if #(.EXP_WIDTH(8), .FRAC_WIDTH(3))  bus_b ();

   dfdd_pixel_source #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .IMG_WIDTH(AW), .IMG_HEIGHT(AH)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .pix   (bus_a.slave)
   );

   dfdd_pixel_source #(.EXP_WIDTH(8), .FRAC_WIDTH(3), .IMG_WIDTH(1), .IMG_HEIGHT(1)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .pix   (bus_b.slave)
   );

   typedef struct {
      logic [31:0] plus;
      logic [31:0] minus;
      int          col;
      int          row;
      bit          fd;
      int          due;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t last_a, last_b, ea, eb;
   int   ca, ra;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference conversion: fraction = (v - 2^p) * 2^f / 2^p, truncated.
   function automatic logic [31:0] to_fp(input int v, input int e, input int f);
      int p;
      int bias;
      int frac;
      if (v == 0) return 32'd0;
      p = 0;
      while ((2 << p) <= v) p++;
      bias = (1 << (e - 1)) - 1;
      frac = ((v - (1 << p)) << f) >> p;
      return 32'(((p + bias) << f) | frac);
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic px_a(input int p, input int m, input bit sof);
      exp_t e;
      bus_a.rho_plus_uint8_i  = 8'(p);
      bus_a.rho_minus_uint8_i = 8'(m);
      bus_a.sof_i             = sof;
      bus_a.valid_i           = 1'b1;
      if (sof) begin
         ca = 0;
         ra = 0;
      end
      e.plus  = to_fp(p, 5, 10);
      e.minus = to_fp(m, 5, 10);
      e.col   = ca;
      e.row   = ra;
      e.fd    = (ca == AW - 1) && (ra == AH - 1);
      e.due   = cyc + 2;
      if (ca == AW - 1) begin
         ca = 0;
         ra = (ra == AH - 1) ? 0 : ra + 1;
      end else begin
         ca++;
      end
      qa.push_back(e);
      @(posedge clk);
      #1;
      bus_a.valid_i = 1'b0;
      bus_a.sof_i   = 1'b0;
   endtask

   task automatic px_b(input int p, input int m, input bit sof);
      exp_t e;
      bus_b.rho_plus_uint8_i  = 8'(p);
      bus_b.rho_minus_uint8_i = 8'(m);
      bus_b.sof_i             = sof;
      bus_b.valid_i           = 1'b1;
      e.plus  = to_fp(p, 8, 3);
      e.minus = to_fp(m, 8, 3);
      e.col   = 0;
      e.row   = 0;
      e.fd    = 1'b1;
      e.due   = cyc + 2;
      qb.push_back(e);
      @(posedge clk);
      #1;
      bus_b.valid_i = 1'b0;
      bus_b.sof_i   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      qa.delete();
      qb.delete();
      @(posedge clk);
      #1;
      ca     = 0;
      ra     = 0;
      last_a = '{default: 0};
      last_b = '{default: 0};
      rst    = 1'b0;
      mon_en = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus_a.valid_o) begin
            if (qa.size() == 0) begin
               check("a_unexpected_valid", 32'(bus_a.valid_o), 32'd0);
            end else begin
               ea = qa.pop_front();
               check("a_latency", 32'(cyc), 32'(ea.due));
               check("a_plus", 32'(bus_a.i_rho_plus_o), ea.plus);
               check("a_minus", 32'(bus_a.i_rho_minus_o), ea.minus);
               check("a_col", 32'(bus_a.col_o), 32'(ea.col));
               check("a_row", 32'(bus_a.row_o), 32'(ea.row));
               check("a_frame_done", 32'(bus_a.frame_done_o), 32'(ea.fd));
               last_a = ea;
            end
         end else begin
            check("a_fd_idle", 32'(bus_a.frame_done_o), 32'd0);
            check("a_hold_plus", 32'(bus_a.i_rho_plus_o), last_a.plus);
            check("a_hold_minus", 32'(bus_a.i_rho_minus_o), last_a.minus);
            check("a_hold_col", 32'(bus_a.col_o), 32'(last_a.col));
            check("a_hold_row", 32'(bus_a.row_o), 32'(last_a.row));
         end
         if (bus_b.valid_o) begin
            if (qb.size() == 0) begin
               check("b_unexpected_valid", 32'(bus_b.valid_o), 32'd0);
            end else begin
               eb = qb.pop_front();
               check("b_latency", 32'(cyc), 32'(eb.due));
               check("b_plus", 32'(bus_b.i_rho_plus_o), eb.plus);
               check("b_minus", 32'(bus_b.i_rho_minus_o), eb.minus);
               check("b_col", 32'(bus_b.col_o), 32'(eb.col));
               check("b_row", 32'(bus_b.row_o), 32'(eb.row));
               check("b_frame_done", 32'(bus_b.frame_done_o), 32'(eb.fd));
               last_b = eb;
            end
         end else begin
            check("b_fd_idle", 32'(bus_b.frame_done_o), 32'd0);
            check("b_hold_minus", 32'(bus_b.i_rho_minus_o), last_b.minus);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int samples[5];
      int k;
      samples = '{0, 1, 3, 128, 255};
      bus_a.rho_plus_uint8_i = '0; bus_a.rho_minus_uint8_i = '0; bus_a.sof_i = 1'b0; bus_a.valid_i = 1'b0;
      bus_b.rho_plus_uint8_i = '0; bus_b.rho_minus_uint8_i = '0; bus_b.sof_i = 1'b0; bus_b.valid_i = 1'b0;
      do_reset();

      check("rst_a_valid", 32'(bus_a.valid_o), 32'd0);
      check("rst_a_fd", 32'(bus_a.frame_done_o), 32'd0);
      check("rst_a_sof_err", 32'(bus_a.sof_err_o), 32'd0);
      check("rst_a_plus", 32'(bus_a.i_rho_plus_o), 32'd0);
      check("rst_a_col", 32'(bus_a.col_o), 32'd0);
      check("rst_b_valid", 32'(bus_b.valid_o), 32'd0);
      check("rst_b_minus", 32'(bus_b.i_rho_minus_o), 32'd0);

      // Conversion corner samples back to back.
      for (int i = 0; i < 5; i++) px_a(samples[i], 255 - samples[i], i == 0);
      idle(4);
      do_reset();

      // One full 4x2 frame plus the first pixel of the next.
      for (int i = 0; i < 9; i++) px_a($urandom_range(0, 255), $urandom_range(0, 255), i == 0);
      idle(4);
      check("a_sof_err_clean", 32'(bus_a.sof_err_o), 32'd0);
      do_reset();

      // Gapped frame, 1 on / 2 off.
      for (int i = 0; i < 8; i++) begin
         px_a($urandom_range(1, 255), $urandom_range(1, 255), i == 0);
         idle(2);
      end
      idle(4);

      // Short frame: sof on the fourth pixel.
      for (int i = 0; i < 3; i++) px_a($urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
      check("a_sof_err_before", 32'(bus_a.sof_err_o), 32'd0);
      px_a($urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
      check("a_sof_err_set", 32'(bus_a.sof_err_o), 32'd1);
      idle(4);
      check("a_sof_err_sticky", 32'(bus_a.sof_err_o), 32'd1);
      do_reset();
      check("a_sof_err_cleared", 32'(bus_a.sof_err_o), 32'd0);

      // Reset while pixels are in flight: neither may emerge.
      px_a(10, 20, 1'b0);
      bus_a.rho_plus_uint8_i  = 8'd30;
      bus_a.rho_minus_uint8_i = 8'd40;
      bus_a.valid_i           = 1'b1;
      rst                     = 1'b1;
      qa.delete();
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus_a.valid_i = 1'b0;
      ca            = 0;
      ra            = 0;
      last_a        = '{default: 0};
      idle(4);
      px_a(77, 88, 1'b0);
      idle(4);

      // 1x1 image with E8/F3: every pixel is a frame end.
      px_b(5, 255, 1'b1);
      px_b(200, 1, 1'b0);
      px_b(0, 0, 1'b1);
      px_b(64, 128, 1'b0);
      for (int i = 0; i < 4; i++) px_b($urandom_range(0, 255), $urandom_range(0, 255), 1'(i & 1));
      idle(4);
      check("b_sof_err", 32'(bus_b.sof_err_o), 32'd0);

      k = 0;
      while ((qa.size() != 0 || qb.size() != 0) && k < 20) begin
         idle(1);
         k++;
      end
      check("a_drain", 32'(qa.size()), 32'd0);
      check("b_drain", 32'(qb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
